// File: rtl/risc_toy_decode_stage.sv
// RISC_TOY decode stage: opcode decode, operand forwarding, load-use stall
// and an ID/EX pipeline register behind a valid/ready handshake.
module risc_toy_decode_stage #(
  parameter int XLEN   = 32,
  parameter int RAW    = 5,
  parameter int PCW    = 30,
  parameter int FWD_EN = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PCW-1:0]   in_pc,
  input  logic             flush,
  output logic [RAW-1:0]   rf_ra0,
  output logic [RAW-1:0]   rf_ra1,
  input  logic [XLEN-1:0]  rf_rd0,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic             ex_wen,
  input  logic [RAW-1:0]   ex_wa,
  input  logic [XLEN-1:0]  ex_wd,
  input  logic             ex_is_load,
  input  logic             wb_wen,
  input  logic [RAW-1:0]   wb_wa,
  input  logic [XLEN-1:0]  wb_wd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_opcode,
  output logic [XLEN-1:0]  out_vala,
  output logic [XLEN-1:0]  out_valb,
  output logic [XLEN-1:0]  out_imm,
  output logic [RAW-1:0]   out_dest,
  output logic             out_wen,
  output logic             out_illegal,
  output logic [PCW-1:0]   out_pc
);

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20;
  localparam logic [4:0] OP_ST   = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

  logic [4:0]      op;
  logic [RAW-1:0]  fld_d;
  logic [RAW-1:0]  fld_a;
  logic [RAW-1:0]  fld_b;
  logic [XLEN-1:0] sext17;
  logic [XLEN-1:0] zext17;
  logic [XLEN-1:0] sext22;
  logic [XLEN-1:0] zext5;
  logic [XLEN-1:0] zext3;

  assign op     = in_instr[31:27];
  assign fld_d  = RAW'(in_instr[26:22]);
  assign fld_a  = RAW'(in_instr[21:17]);
  assign fld_b  = RAW'(in_instr[16:12]);
  assign sext17 = {{(XLEN-17){in_instr[16]}}, in_instr[16:0]};
  assign zext17 = {{(XLEN-17){1'b0}}, in_instr[16:0]};
  assign sext22 = {{(XLEN-22){in_instr[21]}}, in_instr[21:0]};
  assign zext5  = {{(XLEN-5){1'b0}}, in_instr[4:0]};
  assign zext3  = {{(XLEN-3){1'b0}}, in_instr[2:0]};

  logic            use_a;
  logic            use_b;
  logic [RAW-1:0]  src_a_addr;
  logic [RAW-1:0]  src_b_addr;
  logic            valb_const;
  logic [XLEN-1:0] dec_imm;
  logic            dec_wen;
  logic            dec_illegal;

  always_comb begin
    use_a      = 1'b0;
    use_b      = 1'b0;
    src_a_addr = '0;
    src_b_addr = '0;
    valb_const = 1'b0;
    dec_imm    = '0;
    case (op)
      OP_ADDI, OP_LD: begin
        use_a      = 1'b1;
        src_a_addr = fld_a;
        dec_imm    = sext17;
      end
      OP_ANDI, OP_ORI: begin
        use_a      = 1'b1;
        src_a_addr = fld_a;
        dec_imm    = zext17;
      end
      OP_MOVI: dec_imm = sext17;
      OP_ST: begin
        use_a      = 1'b1;
        src_a_addr = fld_a;
        use_b      = 1'b1;
        src_b_addr = fld_d;
        dec_imm    = sext17;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        use_a      = 1'b1;
        src_a_addr = fld_a;
        use_b      = 1'b1;
        src_b_addr = fld_b;
      end
      OP_NEG, OP_NOT: begin
        use_b      = 1'b1;
        src_b_addr = fld_b;
      end
      OP_LSR, OP_ASR, OP_SHL, OP_ROR: begin
        use_a      = 1'b1;
        src_a_addr = fld_a;
        // bit 5 selects register shift amount over the 5-bit immediate
        if (in_instr[5]) begin
          use_b      = 1'b1;
          src_b_addr = fld_b;
        end else begin
          valb_const = 1'b1;
        end
      end
      OP_BR, OP_BRL: begin
        use_a      = 1'b1;
        src_a_addr = fld_b;
        use_b      = 1'b1;
        src_b_addr = fld_a;
        dec_imm    = zext3;
      end
      OP_J, OP_JL, OP_LDR: dec_imm = sext22;
      OP_STR: begin
        use_b      = 1'b1;
        src_b_addr = fld_d;
        dec_imm    = sext22;
      end
      default: ;
    endcase
  end

  assign dec_illegal = (op > OP_STR);
  assign dec_wen     = (op <= OP_ROR) || (op == OP_BRL) || (op == OP_JL) ||
                       (op == OP_LD)  || (op == OP_LDR);

  assign rf_ra0 = src_a_addr;
  assign rf_ra1 = src_b_addr;

  logic [1:0]      src_use;
  logic [RAW-1:0]  src_addr [2];
  logic [XLEN-1:0] rf_data  [2];
  logic [XLEN-1:0] fwd_data [2];
  logic [1:0]      hz_src;

  assign src_use     = {use_b, use_a};
  assign src_addr[0] = src_a_addr;
  assign src_addr[1] = src_b_addr;
  assign rf_data[0]  = rf_rd0;
  assign rf_data[1]  = rf_rd1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic ex_hit;
      logic wb_hit;
      assign ex_hit = src_use[gi] && ex_wen && (ex_wa == src_addr[gi]);
      assign wb_hit = src_use[gi] && wb_wen && (wb_wa == src_addr[gi]);
      assign fwd_data[gi] = ex_hit ? ex_wd : (wb_hit ? wb_wd : rf_data[gi]);
      // without forwarding every in-flight write match must wait it out
      assign hz_src[gi] = (ex_hit && ex_is_load) ||
                          ((FWD_EN == 0) && (ex_hit || wb_hit));
    end
  endgenerate

  logic            hazard;
  logic [XLEN-1:0] vala_next;
  logic [XLEN-1:0] valb_next;

  assign hazard    = in_valid && (|hz_src);
  assign vala_next = use_a ? fwd_data[0] : '0;
  assign valb_next = valb_const ? zext5 : (use_b ? fwd_data[1] : '0);

  logic            valid_reg;
  logic [4:0]      opcode_reg;
  logic [XLEN-1:0] vala_reg;
  logic [XLEN-1:0] valb_reg;
  logic [XLEN-1:0] imm_reg;
  logic [RAW-1:0]  dest_reg;
  logic            wen_reg;
  logic            illegal_reg;
  logic [PCW-1:0]  pc_reg;

  assign in_ready = RSTN && !flush && !hazard && (!valid_reg || out_ready);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      valid_reg   <= 1'b0;
      opcode_reg  <= '0;
      vala_reg    <= '0;
      valb_reg    <= '0;
      imm_reg     <= '0;
      dest_reg    <= '0;
      wen_reg     <= 1'b0;
      illegal_reg <= 1'b0;
      pc_reg      <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_reg   <= 1'b1;
      opcode_reg  <= op;
      vala_reg    <= vala_next;
      valb_reg    <= valb_next;
      imm_reg     <= dec_imm;
      dest_reg    <= fld_d;
      wen_reg     <= dec_wen && !dec_illegal;
      illegal_reg <= dec_illegal;
      pc_reg      <= in_pc;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid   = valid_reg;
  assign out_opcode  = opcode_reg;
  assign out_vala    = vala_reg;
  assign out_valb    = valb_reg;
  assign out_imm     = imm_reg;
  assign out_dest    = dest_reg;
  assign out_wen     = wen_reg;
  assign out_illegal = illegal_reg;
  assign out_pc      = pc_reg;

endmodule
